// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM state codes, peripheral address map
// and the legal-address test used on every transaction.
package periph_bus_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_RESP  = 2'd2;
    localparam state_t S_HOLD  = 2'd3;

    localparam logic [31:0] PERIPH_BASE   = 32'h4000_0000;
    localparam logic [31:0] PERIPH_TOP    = 32'h4000_0020;

    localparam logic [31:0] ADDR_TH       = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL       = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON     = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED      = 32'h4000_000C;
    localparam logic [31:0] ADDR_SWITCH   = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI     = 32'h4000_0014;
    localparam logic [31:0] ADDR_UART_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_UART_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_UART_CON = 32'h4000_0020;

    // Word-aligned and inside the inclusive window; anything else is rejected without a bus access
    function automatic logic addr_legal(input logic [31:0] a,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (a >= lo) && (a <= hi) && (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// Bundle of requester-side handshake and peripheral-side bus signals around the arbiter.
// The slave view is the arbiter itself; the master view is the surrounding masters and peripheral.
interface periph_bus_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ-1:0]      lock;
    logic [32*NREQ-1:0]   addr;
    logic [32*NREQ-1:0]   wdata;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      err;
    logic [31:0]          rdata;
    logic                 bus_rd;
    logic                 bus_wr;
    logic [31:0]          bus_addr;
    logic [31:0]          bus_wdata;
    logic [31:0]          bus_rdata;

    modport slave (
        input  req, we, lock, addr, wdata, bus_rdata,
        output ack, err, rdata, bus_rd, bus_wr, bus_addr, bus_wdata
    );

    modport master (
        output req, we, lock, addr, wdata, bus_rdata,
        input  ack, err, rdata, bus_rd, bus_wr, bus_addr, bus_wdata
    );
endinterface

// File: rtl/periph_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to index 0.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   index,
    output logic            valid
);
    // Upper pass covers ptr..NREQ-1, lower pass handles the wrap-around
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                valid    = 1'b1;
                grant[i] = 1'b1;
                index    = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i]) begin
                valid    = 1'b1;
                grant[i] = 1'b1;
                index    = PW'(i);
            end
        end
    end
endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus among NREQ masters: one transaction in flight,
// exactly one rd/wr strobe per legal transaction, optional lock for read-modify-write sequences.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int          NREQ     = 2,
    parameter logic [31:0] BASE     = PERIPH_BASE,
    parameter logic [31:0] TOP      = PERIPH_TOP,
    parameter int          LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    periph_bus_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 2) ? 2 : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    state_t          state;
    logic [PW-1:0]   rr_ptr, owner, pick_idx, next_ptr;
    logic [NREQ-1:0] pick_grant, owner_oh, sel_oh, ack_q, err_q;
    logic            pick_valid, cur_we, sel_we, legal, take;
    logic [CW-1:0]   lock_cnt;
    logic [31:0]     addr_q, wdata_q, rdata_q, sel_addr, sel_wdata;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .index (pick_idx),
        .valid (pick_valid)
    );

    assign owner_oh = NREQ'(1) << owner;
    assign next_ptr = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
    assign legal    = addr_legal(addr_q, BASE, TOP);
    assign take     = ((state == S_IDLE) && pick_valid) ||
                      ((state == S_HOLD) && bus.req[owner]);

    // While holding a lock only the owner's payload may be latched
    always_comb begin
        sel_oh    = (state == S_HOLD) ? owner_oh : pick_grant;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_oh[i]) begin
                sel_addr  = bus.addr[32*i +: 32];
                sel_wdata = bus.wdata[32*i +: 32];
                sel_we    = bus.we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            lock_cnt <= '0;
            cur_we   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ack_q    <= '0;
            err_q    <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            if (take) begin
                if (state == S_IDLE) owner <= pick_idx;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                cur_we  <= sel_we;
                state   <= S_ISSUE;
            end else begin
                case (state)
                    S_ISSUE: begin
                        // Response pulses are registered here so they appear during RESP
                        if (legal) begin
                            ack_q   <= owner_oh;
                            rdata_q <= bus.bus_rdata;
                        end else begin
                            err_q <= owner_oh;
                        end
                        state <= S_RESP;
                    end
                    S_RESP: begin
                        rr_ptr <= next_ptr;
                        if (bus.lock[owner]) begin
                            lock_cnt <= '0;
                            state    <= S_HOLD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_HOLD: begin
                        if (!bus.lock[owner] || (lock_cnt == CW'(LOCK_MAX - 1))) state <= S_IDLE;
                        else lock_cnt <= lock_cnt + 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_rd    = (state == S_ISSUE) && legal && !cur_we;
    assign bus.bus_wr    = (state == S_ISSUE) && legal && cur_we;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: stimulus pushes hand-computed responses and strobes into
// queues, and a negedge monitor pops and compares whenever the DUT strobes the bus or answers a master.
`timescale 1ns/1ps
module tb_periph_bus_arbiter;
    import periph_bus_pkg::*;

    localparam int NREQ     = 2;
    localparam int LOCK_MAX = 16;

    typedef struct packed {
        logic [1:0]  who;
        logic        is_err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } strobe_t;

    logic    clk = 1'b0;
    logic    reset;
    resp_t   resp_q[$];
    strobe_t strobe_q[$];
    resp_t   mon_r;
    strobe_t mon_s;
    int      n_vec = 0;
    int      n_miss = 0;
    int      cyc = 0;
    int      strobe_cyc = -1;
    int      t0, d0, d1;
    bit      seen;

    always #5 clk = ~clk;

    periph_bus_arbiter_if #(.NREQ(NREQ)) bus ();

    periph_bus_arbiter #(
        .NREQ     (NREQ),
        .BASE     (PERIPH_BASE),
        .TOP      (PERIPH_TOP),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Peripheral read port: SWITCH returns 0x5A, every other register returns a tag of its offset
    function automatic logic [31:0] periph_rd(input logic [31:0] a);
        if (a == ADDR_SWITCH) return 32'h0000_005A;
        return 32'hC0DE_0000 | {24'h0, a[7:0]};
    endfunction

    assign bus.bus_rdata = periph_rd(bus.bus_addr);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectTxn(input int who, input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic is_err, input logic [31:0] rdata_exp);
        resp_q.push_back('{who: 2'(who), is_err: is_err, rdata: rdata_exp});
        if (!is_err) strobe_q.push_back('{wr: wr, addr: a, wdata: d});
    endtask

    task automatic applyStimulus(input int who, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input logic lk);
        bus.we[who]             = wr;
        bus.lock[who]           = lk;
        bus.addr[32*who +: 32]  = a;
        bus.wdata[32*who +: 32] = d;
        bus.req[who]            = 1'b1;
    endtask

    // Waits for this master's ack/err, then drops its request; reports the cycle it completed in
    task automatic waitDone(input int who, output int at_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.ack[who] || bus.err[who]) && n < 60);
        at_cyc = cyc;
        if (!(bus.ack[who] || bus.err[who])) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL timeout master %0d: no ack/err within %0d cycles", who, n);
        end
        bus.req[who] = 1'b0;
    endtask

    // Monitor: every strobe and every response must match the head of its queue
    always @(negedge clk) begin
        if (bus.bus_rd === 1'b1 || bus.bus_wr === 1'b1) begin
            strobe_cyc = cyc;
            checkOutput("strobe_both", 32'(bus.bus_rd & bus.bus_wr), 32'h0);
            if (strobe_q.size() == 0) begin
                checkOutput("unexpected_strobe", {30'h0, bus.bus_wr, bus.bus_rd}, 32'h0);
            end else begin
                mon_s = strobe_q.pop_front();
                checkOutput("strobe_wr", 32'(bus.bus_wr), 32'(mon_s.wr));
                checkOutput("strobe_addr", bus.bus_addr, mon_s.addr);
                if (mon_s.wr) checkOutput("strobe_wdata", bus.bus_wdata, mon_s.wdata);
            end
        end
        if ((|bus.ack) === 1'b1 || (|bus.err) === 1'b1) begin
            if (resp_q.size() == 0) begin
                checkOutput("unexpected_resp", 32'({bus.err, bus.ack}), 32'h0);
            end else begin
                mon_r = resp_q.pop_front();
                checkOutput("resp_ack", 32'(bus.ack), mon_r.is_err ? 32'h0 : (32'h1 << mon_r.who));
                checkOutput("resp_err", 32'(bus.err), mon_r.is_err ? (32'h1 << mon_r.who) : 32'h0);
                checkOutput("resp_rdata", bus.rdata, mon_r.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        bus.req   = '0;
        bus.we    = '0;
        bus.lock  = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_ack", 32'(bus.ack), 32'h0);
        checkOutput("rst_err", 32'(bus.err), 32'h0);
        checkOutput("rst_rdata", bus.rdata, 32'h0);
        checkOutput("rst_bus_rd", 32'(bus.bus_rd), 32'h0);
        checkOutput("rst_bus_wr", 32'(bus.bus_wr), 32'h0);
        checkOutput("rst_bus_addr", bus.bus_addr, 32'h0);
        checkOutput("rst_bus_wdata", bus.bus_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] collision after reset: m0 wins, m1 three cycles later");
        t0 = cyc;
        expectTxn(0, 1'b0, ADDR_TH, 32'h0, 1'b0, 32'hC0DE_0000);
        expectTxn(1, 1'b0, ADDR_TL, 32'h0, 1'b0, 32'hC0DE_0004);
        applyStimulus(0, 1'b0, ADDR_TH, 32'h0, 1'b0);
        applyStimulus(1, 1'b0, ADDR_TL, 32'h0, 1'b0);
        fork
            waitDone(0, d0);
            waitDone(1, d1);
        join
        checkOutput("coll1_m0_cyc", 32'(d0), 32'(t0 + 2));
        checkOutput("coll1_m1_cyc", 32'(d1), 32'(t0 + 5));
        @(negedge clk);

        $display("[TB] single read of SWITCH with latency check");
        t0 = cyc;
        expectTxn(0, 1'b0, ADDR_SWITCH, 32'h0, 1'b0, 32'h0000_005A);
        applyStimulus(0, 1'b0, ADDR_SWITCH, 32'h0, 1'b0);
        waitDone(0, d0);
        checkOutput("read_strobe_cyc", 32'(strobe_cyc), 32'(t0 + 1));
        checkOutput("read_ack_cyc", 32'(d0), 32'(t0 + 2));
        @(negedge clk);

        $display("[TB] collision after m0 served last: m1 wins this round");
        t0 = cyc;
        expectTxn(1, 1'b0, ADDR_DIGI, 32'h0, 1'b0, 32'hC0DE_0014);
        expectTxn(0, 1'b0, ADDR_LED, 32'h0, 1'b0, 32'hC0DE_000C);
        applyStimulus(0, 1'b0, ADDR_LED, 32'h0, 1'b0);
        applyStimulus(1, 1'b0, ADDR_DIGI, 32'h0, 1'b0);
        fork
            waitDone(0, d0);
            waitDone(1, d1);
        join
        checkOutput("coll2_m1_cyc", 32'(d1), 32'(t0 + 2));
        checkOutput("coll2_m0_cyc", 32'(d0), 32'(t0 + 5));
        @(negedge clk);

        $display("[TB] illegal addresses and the inclusive top boundary");
        expectTxn(1, 1'b1, 32'h4000_0024, 32'h1111_1111, 1'b1, 32'hC0DE_000C);
        applyStimulus(1, 1'b1, 32'h4000_0024, 32'h1111_1111, 1'b0);
        waitDone(1, d1);
        @(negedge clk);
        expectTxn(1, 1'b1, 32'h4000_0002, 32'h2222_2222, 1'b1, 32'hC0DE_000C);
        applyStimulus(1, 1'b1, 32'h4000_0002, 32'h2222_2222, 1'b0);
        waitDone(1, d1);
        @(negedge clk);
        expectTxn(1, 1'b1, ADDR_UART_CON, 32'h0000_0003, 1'b0, 32'hC0DE_0020);
        applyStimulus(1, 1'b1, ADDR_UART_CON, 32'h0000_0003, 1'b0);
        waitDone(1, d1);
        @(negedge clk);
        expectTxn(0, 1'b0, 32'h3FFF_FFFC, 32'h0, 1'b1, 32'hC0DE_0020);
        applyStimulus(0, 1'b0, 32'h3FFF_FFFC, 32'h0, 1'b0);
        waitDone(0, d0);
        @(negedge clk);

        $display("[TB] locked read-modify-write by m0 while m1 waits");
        expectTxn(0, 1'b0, ADDR_TCON, 32'h0, 1'b0, 32'hC0DE_0008);
        expectTxn(0, 1'b1, ADDR_TCON, 32'h0000_1234, 1'b0, 32'hC0DE_0008);
        expectTxn(1, 1'b1, ADDR_LED, 32'h0000_ABCD, 1'b0, 32'hC0DE_000C);
        fork
            begin
                applyStimulus(0, 1'b0, ADDR_TCON, 32'h0, 1'b1);
                waitDone(0, d0);
                @(negedge clk);
                applyStimulus(0, 1'b1, ADDR_TCON, 32'h0000_1234, 1'b0);
                waitDone(0, d0);
            end
            begin
                @(negedge clk);
                applyStimulus(1, 1'b1, ADDR_LED, 32'h0000_ABCD, 1'b0);
                waitDone(1, d1);
            end
        join
        @(negedge clk);

        $display("[TB] lock held idle until timeout, then m1 granted");
        expectTxn(0, 1'b0, ADDR_TH, 32'h0, 1'b0, 32'hC0DE_0000);
        expectTxn(1, 1'b0, ADDR_UART_RXD, 32'h0, 1'b0, 32'hC0DE_001C);
        applyStimulus(0, 1'b0, ADDR_TH, 32'h0, 1'b1);
        waitDone(0, d0);
        applyStimulus(1, 1'b0, ADDR_UART_RXD, 32'h0, 1'b0);
        waitDone(1, d1);
        checkOutput("lock_timeout_cyc", 32'(d1), 32'(d0 + LOCK_MAX + 3));
        bus.lock[0] = 1'b0;
        @(negedge clk);

        $display("[TB] reset while a read is on the bus");
        expectTxn(0, 1'b0, ADDR_SWITCH, 32'h0, 1'b0, 32'h0000_005A);
        applyStimulus(0, 1'b0, ADDR_SWITCH, 32'h0, 1'b0);
        waitDone(0, d0);
        @(negedge clk);
        strobe_q.push_back('{wr: 1'b0, addr: ADDR_UART_RXD, wdata: 32'h0});
        applyStimulus(0, 1'b0, ADDR_UART_RXD, 32'h0, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (bus.bus_rd === 1'b1) seen = 1'b1;
        end
        checkOutput("abort_strobe_seen", 32'(seen), 32'h1);
        reset        = 1'b1;
        bus.req[0]   = 1'b0;
        @(negedge clk);
        checkOutput("abort_ack", 32'(bus.ack), 32'h0);
        checkOutput("abort_err", 32'(bus.err), 32'h0);
        checkOutput("abort_rdata", bus.rdata, 32'h0);
        checkOutput("abort_bus_rd", 32'(bus.bus_rd), 32'h0);
        checkOutput("abort_bus_wr", 32'(bus.bus_wr), 32'h0);
        checkOutput("abort_bus_addr", bus.bus_addr, 32'h0);
        checkOutput("abort_bus_wdata", bus.bus_wdata, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] collision after abort: pointer back at m0");
        t0 = cyc;
        expectTxn(0, 1'b0, ADDR_DIGI, 32'h0, 1'b0, 32'hC0DE_0014);
        expectTxn(1, 1'b0, ADDR_TCON, 32'h0, 1'b0, 32'hC0DE_0008);
        applyStimulus(0, 1'b0, ADDR_DIGI, 32'h0, 1'b0);
        applyStimulus(1, 1'b0, ADDR_TCON, 32'h0, 1'b0);
        fork
            waitDone(0, d0);
            waitDone(1, d1);
        join
        checkOutput("coll3_m0_cyc", 32'(d0), 32'(t0 + 2));
        checkOutput("coll3_m1_cyc", 32'(d1), 32'(t0 + 5));
        repeat (4) @(negedge clk);

        checkOutput("resp_queue_left", 32'(resp_q.size()), 32'h0);
        checkOutput("strobe_queue_left", 32'(strobe_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
